// File: rtl/peripheral_ahb3_pkg.sv
// Shared AMBA3 AHB-Lite encodings used by masters, slaves and interconnect.
package peripheral_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8    = 3'b000;
  localparam logic [2:0] HSIZE_B16   = 3'b001;
  localparam logic [2:0] HSIZE_B32   = 3'b010;
  localparam logic [2:0] HSIZE_B64   = 3'b011;
  localparam logic [2:0] HSIZE_B128  = 3'b100;
  localparam logic [2:0] HSIZE_B256  = 3'b101;
  localparam logic [2:0] HSIZE_B512  = 3'b110;
  localparam logic [2:0] HSIZE_B1024 = 3'b111;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/peripheral_ram_1rw_generic.sv
// Generic synchronous RAM with per-byte write enables; a read in the same
// cycle as a write returns the pre-write contents.
module peripheral_ram_1rw_generic #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic                 clk,
  input  logic [WIDTH/8-1:0]   we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [WIDTH-1:0]     q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH / 8; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/peripheral_ahb3_slave_ram.sv
// AHB-Lite slave fronting an on-chip SRAM with configurable wait states,
// two-cycle ERROR responses for illegal accesses and read-after-write forwarding.
module peripheral_ahb3_slave_ram
  import peripheral_ahb3_pkg::*;
#(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  output logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int unsigned BYTES = HDATA_SIZE / 8;
  localparam int unsigned BO    = $clog2(BYTES);
  localparam int unsigned AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]            state, state_nxt;
  logic [3:0]            cnt;
  logic                  wr_q;
  logic [BYTES-1:0]      be_q, fwd_be, lanes, ram_we;
  logic [AW-1:0]         word_q, word_idx;
  logic [HDATA_SIZE-1:0] fwd_data, ram_q;
  logic [HADDR_SIZE-1:0] word_full, align_mask;
  logic                  can_accept, accept, illegal, commit, ram_re;
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

  assign can_accept = (state == ST_IDLE) || (state == ST_LAST) || (state == ST_ERR2);
  assign accept     = can_accept & HSEL & HREADY & HTRANS[1];

  assign word_full  = HADDR >> BO;
  assign align_mask = (HADDR_SIZE'(1) << HSIZE) - HADDR_SIZE'(1);
  assign illegal    = (32'(word_full) >= 32'(MEM_DEPTH)) |
                      (HSIZE > 3'(BO)) |
                      (|(HADDR & align_mask));
  assign word_idx   = HADDR[BO +: AW];

  always_comb begin
    lanes = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      lanes[i] = (i >= 32'(HADDR[BO-1:0])) &&
                 (i < 32'(HADDR[BO-1:0]) + (32'd1 << HSIZE));
    end
  end

  // The write of a finishing data phase lands on the same edge that may accept the next beat.
  assign commit = (state == ST_LAST) & wr_q & HRESETn;
  assign ram_we = commit ? be_q : '0;
  assign ram_re = accept & ~illegal & ~HWRITE;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (!accept)           state_nxt = ST_IDLE;
        else if (illegal)      state_nxt = ST_ERR1;
        else if (WAIT_STATES > 0) state_nxt = ST_WAIT;
        else                   state_nxt = ST_LAST;
      end
      ST_WAIT: if (cnt <= 4'd1) state_nxt = ST_LAST;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      word_q   <= '0;
      fwd_be   <= '0;
      fwd_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= 4'(WAIT_STATES);
        wr_q   <= HWRITE & ~illegal;
        be_q   <= illegal ? '0 : lanes;
        word_q <= word_idx;
        // RAM returns pre-write data on a same-word collision, so keep the written lanes to overlay
        if (!HWRITE && !illegal && commit && (word_idx == word_q)) begin
          fwd_be   <= be_q;
          fwd_data <= HWDATA;
        end else begin
          fwd_be <= '0;
        end
      end else if ((state == ST_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (((state == ST_WAIT) || (state == ST_LAST)) && !wr_q) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        HRDATA[i*8 +: 8] = fwd_be[i] ? fwd_data[i*8 +: 8] : ram_q[i*8 +: 8];
      end
    end
  end

  assign HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  peripheral_ram_1rw_generic #(
    .DEPTH (MEM_DEPTH),
    .WIDTH (HDATA_SIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (HCLK),
    .we    (ram_we),
    .waddr (word_q),
    .wdata (HWDATA),
    .re    (ram_re),
    .raddr (word_idx),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_peripheral_ahb3_slave_ram.sv
// Bench for peripheral_ahb3_slave_ram: three instances (0, 2 and 3 wait states)
// behind one pipelined AHB master, checked against a transaction-level memory model.
module tb_peripheral_ahb3_slave_ram;
  import peripheral_ahb3_pkg::*;

  localparam int NDUT = 3;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        has_exp;
    logic        exp_err;
    logic [31:0] exp_rd;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [15:0] haddr;
  logic [31:0] hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hsel_v  [NDUT];
  logic        hro_v   [NDUT];
  logic        resp_v  [NDUT];
  logic [31:0] rdata_v [NDUT];
  int          sel;
  logic        hro, resp;
  logic [31:0] rdata;

  logic [7:0]  mem_m [NDUT][1024];
  xfer_t       q[$];
  xfer_t       vec [17];
  int          checks = 0;
  int          errors = 0;
  int          phase_cycles;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NDUT; k++) hsel_v[k] = hsel && (sel == k);
  end
  assign hro   = hro_v[sel];
  assign resp  = resp_v[sel];
  assign rdata = rdata_v[sel];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    peripheral_ahb3_slave_ram #(
      .HADDR_SIZE  (16),
      .HDATA_SIZE  (32),
      .MEM_DEPTH   (256),
      .WAIT_STATES ((g == 0) ? 0 : g + 1)
    ) u_dut (
      .HCLK      (clk),
      .HRESETn   (rst_n),
      .HSEL      (hsel_v[g]),
      .HADDR     (haddr),
      .HWDATA    (hwdata),
      .HRDATA    (rdata_v[g]),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HPROT     (hprot),
      .HTRANS    (htrans),
      .HMASTLOCK (hmastlock),
      .HREADY    (hro_v[g]),
      .HREADYOUT (hro_v[g]),
      .HRESP     (resp_v[g])
    );
  end

  function automatic int w_of(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic logic [31:0] pattern(input int i);
    return {8'hC0, 8'(i), 8'h5A, ~8'(i)};
  endfunction

  function automatic xfer_t mk(input logic [1:0] trans, input logic wr, input logic [15:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rd);
    xfer_t x;
    x.trans = trans; x.wr = wr; x.addr = addr; x.size = size; x.wdata = wdata;
    x.has_exp = 1'b1; x.exp_err = exp_err; x.exp_rd = exp_rd;
    return x;
  endfunction

  function automatic bit is_illegal(input xfer_t x);
    int a;
    a = int'(x.addr);
    return (a / 4 >= 256) || (x.size > 3'd2) || ((a % (1 << x.size)) != 0);
  endfunction

  function automatic logic [31:0] exp_word(input int k, input logic [15:0] addr);
    int w;
    w = int'(addr) / 4;
    return {mem_m[k][w*4+3], mem_m[k][w*4+2], mem_m[k][w*4+1], mem_m[k][w*4]};
  endfunction

  task automatic apply_write(input int k, input xfer_t x);
    int off, n, w;
    off = int'(x.addr) % 4;
    n   = 1 << x.size;
    w   = int'(x.addr) / 4;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + n) mem_m[k][w*4+b] = x.wdata[b*8 +: 8];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", name, sel, $time, act, exp);
    end
  endtask

  task automatic drive_addr(input xfer_t x, input bit active);
    hsel   = active;
    htrans = active ? x.trans : HTRANS_IDLE;
    hwrite = x.wr;
    haddr  = x.addr;
    hsize  = x.size;
  endtask

  // Pipelined AHB master: runs everything in q against instance sel and checks each data phase.
  task automatic run_queue();
    xfer_t       a, d;
    bit          a_act, d_act, ready, last, err, act, rd, done;
    int          j;
    logic [31:0] exp_rd;
    a = '{default: '0}; d = '{default: '0};
    d_act = 0; j = 0; exp_rd = '0; done = 0;
    @(posedge clk); #1;
    a_act = (q.size() > 0);
    if (a_act) a = q.pop_front();
    drive_addr(a, a_act);
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      @(negedge clk);
      ready = hro;
      if (d_act) begin
        act = d.trans[1];
        err = act && is_illegal(d);
        if (!act)     last = 1'b1;
        else if (err) last = (j >= 1);
        else          last = (j >= w_of(sel));
        check("hreadyout", 32'(hro), 32'(last));
        check("hresp", 32'(resp), 32'(err));
        if (last) begin
          rd = act && !err && !d.wr;
          check("hrdata", rdata, rd ? exp_rd : 32'h0);
          if (d.has_exp) begin
            check("table_err", 32'(resp), 32'(d.exp_err));
            if (rd) check("table_rdata", rdata, d.exp_rd);
          end
        end
        if (j > 20) begin
          checks++; errors++;
          $display("FAIL data_phase_timeout (dut %0d): hreadyout stuck at %0d expected 1", sel, hro);
          done = 1;
        end
      end
      if (!done) begin
        @(posedge clk); #1;
        if (d_act) phase_cycles++;
        if (ready) begin
          if (d_act && d.trans[1] && d.wr && !is_illegal(d)) apply_write(sel, d);
          d = a; d_act = a_act; j = 0;
          if (d_act) begin
            hwdata = d.wdata;
            if (d.trans[1] && !is_illegal(d) && !d.wr) exp_rd = exp_word(sel, d.addr);
          end
          if (!d_act && q.size() == 0) done = 1;
          a_act = (q.size() > 0);
          if (a_act) a = q.pop_front();
          drive_addr(a, a_act);
        end else begin
          j++;
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL queue_budget (dut %0d): %0d transfers left, required 0", sel, q.size());
      q.delete();
    end
  endtask

  task automatic push_random(input int n);
    xfer_t x;
    logic [15:0] prev = 16'h0;
    int r;
    for (int i = 0; i < n; i++) begin
      x = '{default: '0};
      r = $urandom_range(0, 99);
      x.trans = (r < 45) ? HTRANS_NONSEQ : (r < 80) ? HTRANS_SEQ : (r < 90) ? HTRANS_IDLE : HTRANS_BUSY;
      x.wr    = $urandom_range(0, 1) == 1;
      x.size  = ($urandom_range(0, 9) == 0) ? HSIZE_B64 : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 99);
      if (r < 5)       x.addr = 16'($urandom_range(1024, 65535));
      else if (r < 35) x.addr = (prev & 16'hFFFC) | 16'($urandom_range(0, 3));
      else             x.addr = 16'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) != 0) x.addr = x.addr & ~((16'd1 << x.size) - 16'd1);
      x.wdata = $urandom();
      prev = x.addr;
      q.push_back(x);
    end
  endtask

  initial begin
    xfer_t x;
    rst_n = 1'b0; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
    hsize = HSIZE_B32; hburst = HBURST_SINGLE; hprot = 4'b0011; htrans = HTRANS_IDLE;
    hmastlock = 1'b0; sel = 0;
    for (int k = 0; k < NDUT; k++) for (int b = 0; b < 1024; b++) mem_m[k][b] = 8'h00;

    vec[0]  = mk(HTRANS_NONSEQ, 1, 16'h0010, HSIZE_B32, 32'hDEADBEEF, 0, 32'h0);
    vec[1]  = mk(HTRANS_NONSEQ, 0, 16'h0010, HSIZE_B32, 32'h0,        0, 32'hDEADBEEF);
    vec[2]  = mk(HTRANS_NONSEQ, 1, 16'h0010, HSIZE_B32, 32'h11223344, 0, 32'h0);
    vec[3]  = mk(HTRANS_NONSEQ, 1, 16'h0013, HSIZE_B8,  32'hAA000000, 0, 32'h0);
    vec[4]  = mk(HTRANS_NONSEQ, 0, 16'h0010, HSIZE_B32, 32'h0,        0, 32'hAA223344);
    vec[5]  = mk(HTRANS_NONSEQ, 1, 16'h0020, HSIZE_B32, 32'h55667788, 0, 32'h0);
    vec[6]  = mk(HTRANS_NONSEQ, 0, 16'h0020, HSIZE_B32, 32'h0,        0, 32'h55667788);
    vec[7]  = mk(HTRANS_NONSEQ, 0, 16'h0400, HSIZE_B32, 32'h0,        1, 32'h0);
    vec[8]  = mk(HTRANS_NONSEQ, 1, 16'h0001, HSIZE_B16, 32'h00BEEF00, 1, 32'h0);
    vec[9]  = mk(HTRANS_NONSEQ, 0, 16'h0000, HSIZE_B32, 32'h0,        0, 32'hC0005AFF);
    vec[10] = mk(HTRANS_IDLE,   0, 16'h0000, HSIZE_B32, 32'h0,        0, 32'h0);
    vec[11] = mk(HTRANS_NONSEQ, 1, 16'h0022, HSIZE_B16, 32'hBEEF0000, 0, 32'h0);
    vec[12] = mk(HTRANS_NONSEQ, 0, 16'h0020, HSIZE_B32, 32'h0,        0, 32'hBEEF7788);
    vec[13] = mk(HTRANS_NONSEQ, 0, 16'h03FC, HSIZE_B32, 32'h0,        0, 32'hC0FF5A00);
    vec[14] = mk(HTRANS_NONSEQ, 0, 16'h0008, HSIZE_B64, 32'h0,        1, 32'h0);
    vec[15] = mk(HTRANS_BUSY,   0, 16'h0000, HSIZE_B32, 32'h0,        0, 32'h0);
    vec[16] = mk(HTRANS_NONSEQ, 0, 16'h03FE, HSIZE_B16, 32'h0,        0, 32'hC0FF5A00);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      sel = k; #1;
      check("reset_hreadyout", 32'(hro), 32'd1);
      check("reset_hresp", 32'(resp), 32'd0);
      check("reset_hrdata", rdata, 32'h0);
    end
    rst_n = 1'b1;

    for (int k = 0; k < NDUT; k++) begin
      sel = k;
      for (int i = 0; i < 256; i++) begin
        x = '{default: '0};
        x.trans = (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        x.wr = 1'b1; x.addr = 16'(i * 4); x.size = HSIZE_B32; x.wdata = pattern(i);
        q.push_back(x);
      end
      run_queue();
    end

    sel = 0;
    for (int i = 0; i < 17; i++) q.push_back(vec[i]);
    run_queue();

    sel = 1; hburst = HBURST_INCR4; phase_cycles = 0;
    for (int i = 0; i < 4; i++)
      q.push_back(mk((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 0, 16'(i * 4), HSIZE_B32, 32'h0, 0, pattern(i)));
    run_queue();
    check("incr4_total_cycles", 32'(phase_cycles), 32'd12);
    hburst = HBURST_SINGLE;

    sel = 2;
    @(posedge clk); #1;
    x = mk(HTRANS_NONSEQ, 1, 16'h0030, HSIZE_B32, 32'h12345678, 0, 32'h0);
    drive_addr(x, 1'b1);
    @(posedge clk); #1;
    drive_addr(x, 1'b0);
    hwdata = 32'h12345678;
    @(negedge clk);
    check("pre_reset_wait", 32'(hro), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_hreadyout", 32'(hro), 32'd1);
    check("midreset_hresp", 32'(resp), 32'd0);
    check("midreset_hrdata", rdata, 32'h0);
    q.push_back(mk(HTRANS_NONSEQ, 0, 16'h0030, HSIZE_B32, 32'h0, 0, 32'hC00C5AF3));
    run_queue();

    for (int k = 0; k < NDUT; k++) begin
      sel = k;
      push_random(300);
      run_queue();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
